// File: rtl/fifo_queue.sv
// -----------------------------------------------------------------------------
// fifo_queue
//
// Synchronous circular-buffer FIFO with valid/ready handshakes on both sides.
// Ready/valid outputs come from registered occupancy only, so there is no
// combinational path from enqueue to dequeue or from deq_rdy to enq_rdy.
// A full queue refuses writes even when a read fires in the same cycle, and an
// empty queue never bypasses an arriving message to the output.
//
// Parameters:
//   p_nbits  message width in bits (>= 1)
//   p_depth  number of entries (power of two, >= 2)
//
// Ports:
//   clk      clock, all state updates on posedge
//   rst      asynchronous active-low reset; clears pointers, count and storage
//   enq_val  producer offers enq_msg
//   enq_rdy  queue not full
//   enq_msg  message to write
//   deq_val  queue not empty
//   deq_rdy  consumer takes the head entry this cycle
//   deq_msg  head entry (combinational read of storage[rptr])
//   count    current occupancy, 0..p_depth
// -----------------------------------------------------------------------------
module fifo_queue #(
    parameter int p_nbits = 8,
    parameter int p_depth = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq_val,
    output logic                       enq_rdy,
    input  logic [p_nbits-1:0]         enq_msg,
    output logic                       deq_val,
    input  logic                       deq_rdy,
    output logic [p_nbits-1:0]         deq_msg,
    output logic [$clog2(p_depth):0]   count
);

    localparam int AW = $clog2(p_depth);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(p_depth);

    logic [p_nbits-1:0] storage [p_depth];
    logic [AW-1:0]      wptr;
    logic [AW-1:0]      rptr;
    logic [CW-1:0]      count_q;
    logic               enq_fire;
    logic               deq_fire;

    assign enq_rdy  = (count_q != FULL_COUNT);
    assign deq_val  = (count_q != '0);
    assign enq_fire = enq_val & enq_rdy;
    assign deq_fire = deq_val & deq_rdy;
    assign deq_msg  = storage[rptr];
    assign count    = count_q;

    // Storage is reset so deq_msg is never X, even while the queue is empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < p_depth; i++) begin
                storage[i] <= '0;
            end
        end else if (enq_fire) begin
            storage[wptr] <= enq_msg;
        end
    end

    // Pointers wrap through natural overflow since p_depth is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (enq_fire) begin
                wptr <= wptr + 1'b1;
            end
            if (deq_fire) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            case ({enq_fire, deq_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_queue.sv
// -----------------------------------------------------------------------------
// tb_fifo_queue
//
// Directed bench for fifo_queue (p_nbits=8, p_depth=4). Inputs change and
// outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_queue;

    logic       clk;
    logic       rst;
    logic       enq_val;
    logic       enq_rdy;
    logic [7:0] enq_msg;
    logic       deq_val;
    logic       deq_rdy;
    logic [7:0] deq_msg;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    fifo_queue #(.p_nbits(8), .p_depth(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .enq_val (enq_val),
        .enq_rdy (enq_rdy),
        .enq_msg (enq_msg),
        .deq_val (deq_val),
        .deq_rdy (deq_rdy),
        .deq_msg (deq_msg),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [2:0] exp_count,
                             input logic exp_rdy, input logic exp_val);
        chk({tag, "_count"}, {29'd0, count}, {29'd0, exp_count});
        chk({tag, "_enq_rdy"}, {31'd0, enq_rdy}, {31'd0, exp_rdy});
        chk({tag, "_deq_val"}, {31'd0, deq_val}, {31'd0, exp_val});
    endtask

    logic [7:0] sim_exp [6];

    initial begin
        rst     = 1'b0;
        enq_val = 1'b0;
        enq_msg = 8'h00;
        deq_rdy = 1'b0;
        sim_exp[0] = 8'h10; sim_exp[1] = 8'h11; sim_exp[2] = 8'h20;
        sim_exp[3] = 8'h21; sim_exp[4] = 8'h22; sim_exp[5] = 8'h23;

        // Reset outputs without any clock edge having occurred
        #2;
        chk_state("reset0", 3'd0, 1'b1, 1'b0);
        chk("reset0_msg", {24'd0, deq_msg}, 32'h00);

        step();
        rst = 1'b1;
        step();
        step();
        chk_state("idle", 3'd0, 1'b1, 1'b0);
        chk("idle_msg", {24'd0, deq_msg}, 32'h00);

        // Dequeue request on empty queue changes nothing
        deq_rdy = 1'b1;
        step();
        deq_rdy = 1'b0;
        chk_state("empty_deq", 3'd0, 1'b1, 1'b0);

        // Single pass
        enq_val = 1'b1; enq_msg = 8'hA5;
        step();
        enq_val = 1'b0; enq_msg = 8'h5A;
        chk_state("single_enq", 3'd1, 1'b1, 1'b1);
        chk("single_msg", {24'd0, deq_msg}, 32'hA5);
        deq_rdy = 1'b1;
        step();
        deq_rdy = 1'b0;
        chk_state("single_deq", 3'd0, 1'b1, 1'b0);

        // Fill to full
        for (int i = 1; i <= 4; i++) begin
            enq_val = 1'b1;
            enq_msg = 8'(i);
            step();
        end
        chk_state("full", 3'd4, 1'b0, 1'b1);
        enq_msg = 8'h05;
        step();
        enq_val = 1'b0;
        chk_state("full_ignore", 3'd4, 1'b0, 1'b1);
        chk("full_head", {24'd0, deq_msg}, 32'h01);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain_%0d", i), {24'd0, deq_msg}, 32'(i));
            deq_rdy = 1'b1;
            step();
            deq_rdy = 1'b0;
        end
        chk_state("drained", 3'd0, 1'b1, 1'b0);

        // Simultaneous enqueue and dequeue with pointer wrap
        enq_val = 1'b1; enq_msg = 8'h10;
        step();
        enq_msg = 8'h11;
        step();
        chk_state("preload", 3'd2, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            enq_msg = 8'h20 + 8'(k);
            deq_rdy = 1'b1;
            chk($sformatf("simul_msg_%0d", k), {24'd0, deq_msg}, {24'd0, sim_exp[k]});
            step();
            chk($sformatf("simul_cnt_%0d", k), {29'd0, count}, 32'd2);
        end
        enq_val = 1'b0;
        chk("simul_tail0", {24'd0, deq_msg}, 32'h24);
        step();
        chk("simul_tail1", {24'd0, deq_msg}, 32'h25);
        step();
        deq_rdy = 1'b0;
        chk_state("simul_done", 3'd0, 1'b1, 1'b0);

        // Full queue with both sides active: only dequeue fires
        for (int i = 0; i < 4; i++) begin
            enq_val = 1'b1;
            enq_msg = 8'h30 + 8'(i);
            step();
        end
        enq_msg = 8'h34;
        deq_rdy = 1'b1;
        #1;
        chk("full_rdy_indep", {31'd0, enq_rdy}, 32'd0);
        step();
        chk_state("full_deq", 3'd3, 1'b1, 1'b1);
        chk("full_deq_head", {24'd0, deq_msg}, 32'h31);
        deq_rdy = 1'b0;
        step();
        enq_val = 1'b0;
        chk_state("full_refill", 3'd4, 1'b0, 1'b1);

        // Reset mid-operation with 3 entries held
        deq_rdy = 1'b1;
        step();
        deq_rdy = 1'b0;
        chk("pre_reset_cnt", {29'd0, count}, 32'd3);
        #2;
        rst = 1'b0;
        #1;
        chk_state("mid_reset", 3'd0, 1'b1, 1'b0);
        chk("mid_reset_msg", {24'd0, deq_msg}, 32'h00);
        step();
        rst = 1'b1;
        enq_val = 1'b1; enq_msg = 8'h77;
        step();
        enq_val = 1'b0;
        chk_state("post_reset", 3'd1, 1'b1, 1'b1);
        chk("post_reset_msg", {24'd0, deq_msg}, 32'h77);
        deq_rdy = 1'b1;
        step();
        deq_rdy = 1'b0;
        chk_state("post_reset_deq", 3'd0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
